// File: rtl/cnt_pkg.sv
// Shared types and constants for the configurable stride counter.
// Holds the control state encoding and the width of the optional wrap statistic.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WRAP_STAT_W = 16;

endpackage

// File: rtl/cnt_stride_wrap.sv
// Combinational next-count stage: adds the stride and folds the result modulo L.
// A limit of zero stands for the full 2^CNT_WIDTH range.
module cnt_stride_wrap #(
  parameter int CNT_WIDTH  = 6,
  parameter int STEP_WIDTH = 3
) (
  input  logic [CNT_WIDTH-1:0]  i_cnt,
  input  logic [STEP_WIDTH-1:0] i_step,
  input  logic [CNT_WIDTH-1:0]  i_limit,
  output logic [CNT_WIDTH-1:0]  o_next,
  output logic                  o_wrap,
  output logic                  o_ovf
);

  localparam logic [CNT_WIDTH:0] FULL_RANGE = {1'b1, {CNT_WIDTH{1'b0}}};

  logic [CNT_WIDTH:0] w_limitExt;
  logic [CNT_WIDTH:0] w_sum;
  logic [CNT_WIDTH:0] w_residue;

  assign w_limitExt = (i_limit == '0) ? FULL_RANGE : {1'b0, i_limit};
  assign w_sum      = {1'b0, i_cnt} + {{(CNT_WIDTH + 1 - STEP_WIDTH){1'b0}}, i_step};
  assign w_residue  = w_sum - w_limitExt;

  // A residue that would still be out of range (huge step or loaded count past L) clamps to zero.
  always_comb begin
    o_next = i_cnt;
    o_wrap = 1'b0;
    o_ovf  = 1'b0;
    if (i_step != '0) begin
      if (w_sum < w_limitExt) begin
        o_next = w_sum[CNT_WIDTH-1:0];
      end else begin
        o_wrap = 1'b1;
        o_ovf  = (w_residue != '0);
        if (w_residue >= w_limitExt) begin
          o_next = '0;
          o_ovf  = 1'b1;
        end else begin
          o_next = w_residue[CNT_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/configurable_stride_counter.sv
// Programmable-stride modulo counter with load handshake and one-shot/free-run modes.
// Define CNT_WRAP_STAT_EN to add the saturating wrap_cnt_o wrap statistic port.
module configurable_stride_counter
  import cnt_pkg::*;
#(
  parameter int CNT_WIDTH  = 6,
  parameter int STEP_WIDTH = 3,
  parameter int RST_LIMIT  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [CNT_WIDTH-1:0]  load_cnt_i,
  input  logic [CNT_WIDTH-1:0]  load_limit_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  oneshot_i,
  input  logic [STEP_WIDTH-1:0] step_i,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  end_o,
  output logic                  overflow_o
`ifdef CNT_WRAP_STAT_EN
  ,
  output logic [WRAP_STAT_W-1:0] wrap_cnt_o
`endif
);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_limit;
  logic                 r_oneshot;
  logic                 r_end;
  logic                 r_ovf;

  logic [CNT_WIDTH-1:0] w_next;
  logic                 w_wrap;
  logic                 w_ovf;

  cnt_stride_wrap #(
    .CNT_WIDTH (CNT_WIDTH),
    .STEP_WIDTH(STEP_WIDTH)
  ) u_wrap (
    .i_cnt  (r_cnt),
    .i_step (step_i),
    .i_limit(r_limit),
    .o_next (w_next),
    .o_wrap (w_wrap),
    .o_ovf  (w_ovf)
  );

  // Loads are only accepted while stopped; a load together with start goes straight to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_limit   <= CNT_WIDTH'(RST_LIMIT);
      r_oneshot <= 1'b0;
      r_end     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_end <= 1'b0;
      r_ovf <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (load_valid_i) begin
            r_cnt   <= load_cnt_i;
            r_limit <= load_limit_i;
            r_state <= IDLE;
          end
          if (start_i) begin
            r_state   <= RUN;
            r_oneshot <= oneshot_i;
          end
        end
        RUN: begin
          if (stop_i) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= w_next;
            r_end <= w_wrap;
            r_ovf <= w_ovf;
            if (w_wrap && r_oneshot) r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_ready_o = (r_state != RUN);
  assign busy_o       = (r_state == RUN);
  assign done_o       = (r_state == DONE);
  assign cnt_o        = r_cnt;
  assign end_o        = r_end;
  assign overflow_o   = r_ovf;

`ifdef CNT_WRAP_STAT_EN
  logic [WRAP_STAT_W-1:0] r_wrapCnt;

  // Counts the same events that raise end_o next cycle, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrapCnt <= '0;
    end else if (load_valid_i && load_ready_o) begin
      r_wrapCnt <= '0;
    end else if ((r_state == RUN) && !stop_i && w_wrap && (r_wrapCnt != '1)) begin
      r_wrapCnt <= r_wrapCnt + 1'b1;
    end
  end

  assign wrap_cnt_o = r_wrapCnt;
`endif

endmodule
